tpumac_pipe: RTL and testbench
==============================

Name: tpumac_pipe

Overview:
- Parametrised next-generation systolic MAC processing element for the TPU array.
- Forwards A/B operands to neighbouring PEs with 1-cycle latency; accumulates A*B into C.
- Adds configurable operand/accumulator widths, a pipelined multiplier, signed/unsigned mode, optional saturation, a sticky overflow flag and an in-flight indicator.
- Instantiated as one PE per grid point in the systolic array.

Parameters:
- DATA_W, 8, A/B operand width in bits (>=2).
- ACC_W, 16, accumulator / Cin / Cout width in bits (must be >= 2*DATA_W).
- MUL_STAGES, 1, multiply-to-accumulate latency in cycles (>=1); 1 gives single-cycle MAC timing.
- SIGNED, 1, 1 = two's-complement operands and accumulator; 0 = unsigned.
- SATURATE, 0, 1 = clamp accumulator on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  issue enable; op sampled at the rising edge when en=1.
- WrEn  in  1  with en=1, the issued op loads Cin instead of accumulating.
- Ain  in  DATA_W  row operand.
- Bin  in  DATA_W  column operand.
- Cin  in  ACC_W  accumulator preload value.
- Aout  out  DATA_W  registered Ain forwarded to the next PE.
- Bout  out  DATA_W  registered Bin forwarded to the next PE.
- Cout  out  ACC_W  accumulator value.
- ovf  out  1  sticky overflow flag.
- busy  out  1  high while any issued op has not yet reached Cout.

Behaviour:
- Reset: when rst=1 at an edge, Aout, Bout, Cout, ovf, busy and all pipeline valid bits go to 0. rst overrides all other inputs in the same cycle.
- Forwarding: at an edge with en=1, Aout<=Ain and Bout<=Bin. With en=0, Aout/Bout hold. Forwarding latency is always 1, independent of MUL_STAGES.
- Issue: en=1 pushes op {wr=WrEn, Cin, P=Ain*Bin} into the pipeline. en=0 issues nothing; a WrEn with en=0 is ignored.
- Product width: P is computed at 2*DATA_W bits, then sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W.
- Pipeline timing:
  - The pipeline advances every cycle, regardless of en. Each stage carries a valid bit.
  - MUL_STAGES-1 product register stages are followed by the accumulator register.
  - An op sampled at edge k updates Cout at edge k+MUL_STAGES-1. With MUL_STAGES=1, Cout updates at the same edge as Aout/Bout.
  - The pipeline accepts one op per cycle and never stalls or drops ops.
- Accumulate: a valid op with wr=0 gives Cout<=Cout+P. A valid op with wr=1 gives Cout<=Cin (the Cin captured at issue) and also clears ovf. Stages with no valid op leave Cout and ovf unchanged.
- Overflow detection:
  - SIGNED=1: overflow when Cout and P have the same sign and the sum's sign differs.
  - SIGNED=0: overflow on carry-out of bit ACC_W-1.
- Overflow response:
  - SATURATE=0: the sum wraps modulo 2^ACC_W.
  - SATURATE=1: the result clamps to max (signed 2^(ACC_W-1)-1, unsigned 2^ACC_W-1), or to signed min -2^(ACC_W-1) on negative overflow.
  - In both modes, ovf<=1 and stays set until rst or a wr=1 op retires.
- busy: OR of all in-flight valid bits, including the op issued this cycle that has not yet retired. For MUL_STAGES=1, busy is always 0.
- Back-to-back ops: a wr=1 op followed by wr=0 ops on consecutive cycles accumulate onto the loaded value with no bubble.
- Reset mid-operation: all in-flight ops are discarded; no partial update of Cout after reset.

Test Plan:
- Reset check: default params, drive rst=1 for 1 cycle, then rst=0 -> Aout=0, Bout=0, Cout=0, ovf=0, busy=0.
- Sequential accumulation: default params, en=1, WrEn=0, sweep Ain=i, Bin=j for i,j in 1..10 -> each cycle Aout/Bout equal the previous inputs; after 100 ops Cout=3025.
- Pipelined timing: MUL_STAGES=3, issue WrEn=1/Cin=100, then A=3/B=4, then A=-2/B=5 on consecutive cycles, en=0 afterwards:
  - Cout=100, 112, 102 at issue-edge+2 for each op respectively.
  - busy=1 from the first issue until the last op retires.
- Signed saturation: SATURATE=1, load Cin=32000, issue A=127/B=127 -> Cout=32767, ovf=1. Then load WrEn Cin=0 -> ovf=0.
- Wrap and unsigned mode:
  - SATURATE=0, load Cin=32760, issue A=4/B=4 -> Cout=-32760, ovf=1.
  - SIGNED=0, load Cin=65530, issue A=3/B=3 -> Cout=3 (wrap), ovf=1.
- Random with stalls and reset: 500 cycles of random en/WrEn(every 20th)/A/B/Cin against a latency-aware reference model. Assert rst mid-burst with MUL_STAGES=3 -> in-flight ops discarded, Cout=0 next cycle, zero mismatches overall.

Source files
------------

// File: rtl/tpumac_pipe.sv
// tpumac_pipe: systolic MAC processing element.
// A/B operands are forwarded to neighbouring PEs one cycle after issue.
// Each issued op travels through MUL_STAGES-1 product registers and then
// retires into the accumulator. A retiring op either loads Cin or adds A*B.
// Signed/unsigned operation, wrap or saturation, a sticky overflow flag and
// an in-flight indicator are all selected by parameters.
module tpumac_pipe #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 16,
  parameter int MUL_STAGES = 1,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              WrEn,
  input  logic [DATA_W-1:0] Ain,
  input  logic [DATA_W-1:0] Bin,
  input  logic [ACC_W-1:0]  Cin,
  output logic [DATA_W-1:0] Aout,
  output logic [DATA_W-1:0] Bout,
  output logic [ACC_W-1:0]  Cout,
  output logic              ovf,
  output logic              busy
);

  localparam int PW = 2 * DATA_W;

  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};

  // Returns {overflow, wrapped sum}. Signed overflow means both addends have
  // the same sign and the sum has the other sign. Unsigned overflow is the
  // carry out of the top bit.
  function automatic logic [ACC_W:0] add_ovf(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    logic           o;
    s = {1'b0, a} + {1'b0, b};
    if (SIGNED != 0)
      o = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    else
      o = s[ACC_W];
    return {o, s[ACC_W-1:0]};
  endfunction

  // Clamps an overflowed sum. In signed mode the direction follows the sign
  // shared by both addends, which is the sign of the old accumulator.
  function automatic logic [ACC_W-1:0] saturate(input logic [ACC_W-1:0] sum,
                                                input logic             o,
                                                input logic             neg);
    logic [ACC_W-1:0] r;
    r = sum;
    if ((SATURATE != 0) && o) begin
      if (SIGNED != 0)
        r = neg ? SMIN : SMAX;
      else
        r = UMAX;
    end
    return r;
  endfunction

  // ---- stage p0: product of the operands presented at issue ----
  logic [ACC_W-1:0] prod_p0;

  generate
    if (SIGNED != 0) begin : g_smul
      logic signed [PW-1:0] a_s, b_s, p_s;
      assign a_s     = PW'($signed(Ain));
      assign b_s     = PW'($signed(Bin));
      assign p_s     = a_s * b_s;
      assign prod_p0 = ACC_W'(p_s);
    end else begin : g_umul
      logic [PW-1:0] p_u;
      assign p_u     = PW'(Ain) * PW'(Bin);
      assign prod_p0 = ACC_W'(p_u);
    end
  endgenerate

  // ---- stages p1..pN: product registers feeding the accumulator ----
  logic             vld_pn;
  logic             wr_pn;
  logic [ACC_W-1:0] cin_pn;
  logic [ACC_W-1:0] prod_pn;

  generate
    if (MUL_STAGES > 1) begin : g_pipe
      localparam int RS = MUL_STAGES - 1;
      logic [RS-1:0]    vld_p1;
      logic             wr_p1   [RS];
      logic [ACC_W-1:0] cin_p1  [RS];
      logic [ACC_W-1:0] prod_p1 [RS];

      // Valid bits shift every cycle. Reset discards every in-flight op.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p1 <= '0;
        end else begin
          vld_p1[0] <= en;
          for (int i = 1; i < RS; i++) vld_p1[i] <= vld_p1[i-1];
        end
      end

      // Op payload shifts alongside its valid bit. It is ignored when not valid.
      always_ff @(posedge clk) begin
        wr_p1[0]   <= WrEn;
        cin_p1[0]  <= Cin;
        prod_p1[0] <= prod_p0;
        for (int i = 1; i < RS; i++) begin
          wr_p1[i]   <= wr_p1[i-1];
          cin_p1[i]  <= cin_p1[i-1];
          prod_p1[i] <= prod_p1[i-1];
        end
      end

      assign vld_pn  = vld_p1[RS-1];
      assign wr_pn   = wr_p1[RS-1];
      assign cin_pn  = cin_p1[RS-1];
      assign prod_pn = prod_p1[RS-1];
      assign busy    = |vld_p1;
    end else begin : g_direct
      assign vld_pn  = en;
      assign wr_pn   = WrEn;
      assign cin_pn  = Cin;
      assign prod_pn = prod_p0;
      assign busy    = 1'b0;
    end
  endgenerate

  // ---- accumulator stage ----
  logic [ACC_W-1:0] sum_add;
  logic             ovf_add;
  logic [ACC_W-1:0] acc_next;

  // Next accumulator value for a retiring accumulate op.
  always_comb begin
    {ovf_add, sum_add} = add_ovf(Cout, prod_pn);
    acc_next           = saturate(sum_add, ovf_add, Cout[ACC_W-1]);
  end

  // Operand forwarding to the neighbouring PEs, one cycle after issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      Aout <= '0;
      Bout <= '0;
    end else if (en) begin
      Aout <= Ain;
      Bout <= Bin;
    end
  end

  // Accumulator and sticky overflow. They change only when an op retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      Cout <= '0;
      ovf  <= 1'b0;
    end else if (vld_pn) begin
      if (wr_pn) begin
        Cout <= cin_pn;
        ovf  <= 1'b0;
      end else begin
        Cout <= acc_next;
        if (ovf_add) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tpumac_pipe.sv
// tb_tpumac_pipe: drives shared stimulus into several tpumac_pipe
// configurations at once. Every output is checked each cycle against a
// reference model. The model keeps a history of issued ops and evaluates
// the accumulator with plain integer arithmetic and range checks.
module tb_tpumac_pipe;

  localparam int NC = 5;
  localparam int MS_T [NC] = '{1, 3, 2, 2, 1};
  localparam int SG_T [NC] = '{1, 1, 1, 0, 0};
  localparam int ST_T [NC] = '{0, 0, 1, 0, 1};
  localparam int HN = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        wren = 1'b0;
  logic [7:0]  ain = '0;
  logic [7:0]  bin = '0;
  logic [15:0] cin = '0;

  logic [7:0]  aout_w [NC];
  logic [7:0]  bout_w [NC];
  logic [15:0] cout_w [NC];
  logic        ovf_w  [NC];
  logic        busy_w [NC];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    tpumac_pipe #(
      .DATA_W(8), .ACC_W(16), .MUL_STAGES(MS_T[g]),
      .SIGNED(SG_T[g]), .SATURATE(ST_T[g])
    ) u_dut (
      .clk(clk), .rst(rst), .en(en), .WrEn(wren),
      .Ain(ain), .Bin(bin), .Cin(cin),
      .Aout(aout_w[g]), .Bout(bout_w[g]), .Cout(cout_w[g]),
      .ovf(ovf_w[g]), .busy(busy_w[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Per-edge history of what was presented to the PE.
  bit          hist_en  [HN];
  bit          hist_wr  [HN];
  logic [7:0]  hist_a   [HN];
  logic [7:0]  hist_b   [HN];
  logic [15:0] hist_cin [HN];
  int          n_edge   = 0;
  int          last_rst = 0;

  longint      m_acc  [NC];
  bit          m_ovf  [NC];
  bit          m_busy [NC];
  logic [7:0]  m_a = '0;
  logic [7:0]  m_b = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Retires the op issued at edge j into configuration c.
  function automatic void retire(int c, int j);
    longint p, s;
    if (hist_wr[j]) begin
      m_acc[c] = (SG_T[c] != 0) ? longint'($signed(hist_cin[j])) : longint'(hist_cin[j]);
      m_ovf[c] = 1'b0;
      return;
    end
    if (SG_T[c] != 0)
      p = longint'($signed(hist_a[j])) * longint'($signed(hist_b[j]));
    else
      p = longint'(hist_a[j]) * longint'(hist_b[j]);
    s = m_acc[c] + p;
    if (SG_T[c] != 0) begin
      if (s > 32767 || s < -32768) begin
        m_ovf[c] = 1'b1;
        if (ST_T[c] != 0) begin
          s = (s > 0) ? 64'sd32767 : -64'sd32768;
        end else begin
          s = s & 64'sd65535;
          if (s > 32767) s = s - 65536;
        end
      end
    end else begin
      if (s > 65535) begin
        m_ovf[c] = 1'b1;
        s = (ST_T[c] != 0) ? 64'sd65535 : s - 65536;
      end
    end
    m_acc[c] = s;
  endfunction

  // Advances the model by one rising edge using the inputs just sampled.
  // The op issued at edge j retires at edge j+MS-1, unless a reset came
  // at or after j.
  function automatic void model_edge();
    int j;
    n_edge++;
    hist_en[n_edge]  = en;
    hist_wr[n_edge]  = wren;
    hist_a[n_edge]   = ain;
    hist_b[n_edge]   = bin;
    hist_cin[n_edge] = cin;
    if (rst) begin
      last_rst = n_edge;
      m_a = '0;
      m_b = '0;
      for (int c = 0; c < NC; c++) begin
        m_acc[c]  = 0;
        m_ovf[c]  = 1'b0;
        m_busy[c] = 1'b0;
      end
      return;
    end
    if (en) begin
      m_a = ain;
      m_b = bin;
    end
    for (int c = 0; c < NC; c++) begin
      j = n_edge - MS_T[c] + 1;
      if (j > last_rst && hist_en[j]) retire(c, j);
      m_busy[c] = 1'b0;
      for (int k = n_edge - MS_T[c] + 2; k <= n_edge; k++)
        if (k > last_rst && hist_en[k]) m_busy[c] = 1'b1;
    end
  endfunction

  task automatic compare_all();
    logic [15:0] e;
    for (int c = 0; c < NC; c++) begin
      e = 16'(m_acc[c]);
      check($sformatf("cout[%0d]", c), 32'(cout_w[c]), 32'(e));
      check($sformatf("ovf[%0d]", c),  32'(ovf_w[c]),  32'(m_ovf[c]));
      check($sformatf("busy[%0d]", c), 32'(busy_w[c]), 32'(m_busy[c]));
      check($sformatf("aout[%0d]", c), 32'(aout_w[c]), 32'(m_a));
      check($sformatf("bout[%0d]", c), 32'(bout_w[c]), 32'(m_b));
    end
  endtask

  // One clock: drive inputs, step the model at the edge, then check after it.
  task automatic cyc(input bit r, input bit e, input bit w,
                     input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
    @(negedge clk);
    rst  = r;
    en   = e;
    wren = w;
    ain  = a;
    bin  = b;
    cin  = c;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 16'($urandom));
  endtask

  initial begin
    // Reset and its visible state.
    cyc(1'b1, 1'b1, 1'b0, 8'h55, 8'hAA, 16'h1234);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
    check("rst_cout", 32'(cout_w[0]), 32'd0);
    check("rst_aout", 32'(aout_w[0]), 32'd0);
    check("rst_ovf",  32'(ovf_w[1]),  32'd0);
    check("rst_busy", 32'(busy_w[1]), 32'd0);

    // Sequential accumulation sweep: the sum of i*j for i,j in 1..10 is 55*55.
    for (int i = 1; i <= 10; i++)
      for (int j = 1; j <= 10; j++)
        cyc(1'b0, 1'b1, 1'b0, 8'(i), 8'(j), 16'($urandom));
    check("sweep_cout", 32'(cout_w[0]), 32'd3025);

    // Pipelined timing on the three-stage instance.
    cyc(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 16'd100);
    check("pipe_busy0", 32'(busy_w[1]), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 8'd3, 8'd4, 16'd0);
    check("pipe_busy1", 32'(busy_w[1]), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 8'hFE, 8'd5, 16'd0);
    check("pipe_load", 32'(cout_w[1]), 32'd100);
    check("pipe_busy2", 32'(busy_w[1]), 32'd1);
    idle();
    check("pipe_mac1", 32'(cout_w[1]), 32'd112);
    check("pipe_busy3", 32'(busy_w[1]), 32'd1);
    idle();
    check("pipe_mac2", 32'(cout_w[1]), 32'd102);
    check("pipe_idle", 32'(busy_w[1]), 32'd0);

    // Signed saturation, then a load clears the sticky flag.
    cyc(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 16'd32000);
    cyc(1'b0, 1'b1, 1'b0, 8'd127, 8'd127, 16'd0);
    idle(); idle();
    check("sat_cout", 32'(cout_w[2]), 32'd32767);
    check("sat_ovf",  32'(ovf_w[2]),  32'd1);
    cyc(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 16'd0);
    idle(); idle();
    check("sat_clr", 32'(ovf_w[2]), 32'd0);

    // Signed wrap.
    cyc(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 16'd32760);
    cyc(1'b0, 1'b1, 1'b0, 8'd4, 8'd4, 16'd0);
    idle(); idle();
    check("wrap_cout", 32'(cout_w[0]), 32'h8008);
    check("wrap_ovf",  32'(ovf_w[0]),  32'd1);

    // Unsigned wrap and unsigned saturation.
    cyc(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 16'd65530);
    cyc(1'b0, 1'b1, 1'b0, 8'd3, 8'd3, 16'd0);
    idle(); idle();
    check("uwrap_cout", 32'(cout_w[3]), 32'd3);
    check("uwrap_ovf",  32'(ovf_w[3]),  32'd1);
    check("usat_cout",  32'(cout_w[4]), 32'd65535);

    // Random traffic with stalls, periodic loads and a mid-burst reset.
    for (int i = 0; i < 500; i++) begin
      bit e, w;
      e = ($urandom_range(0, 3) != 0);
      w = e ? (i % 20 == 0) : 1'($urandom);
      if (i == 250) begin
        cyc(1'b1, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 16'($urandom));
        check("midrst_cout", 32'(cout_w[1]), 32'd0);
        check("midrst_busy", 32'(busy_w[1]), 32'd0);
      end else begin
        cyc(1'b0, e, w, 8'($urandom), 8'($urandom), 16'($urandom));
      end
    end
    idle(); idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
